// File: rtl/instr_mem_loader_if.sv
// Loader byte-stream and CPU fetch bus for instr_mem_loader.
// The master side is the program source / CPU; the slave side is the loader.
interface instr_mem_loader_if;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_end;
    logic        load_ready;
    logic        loading;
    logic [16:0] word_count;
    logic        fault;
    logic [31:0] sel;
    logic [31:0] out;
    logic        addr_err;

    modport master (
        output load_start, load_valid, load_byte, load_end, sel,
        input  load_ready, loading, word_count, fault, out, addr_err
    );

    modport slave (
        input  load_start, load_valid, load_byte, load_end, sel,
        output load_ready, loading, word_count, fault, out, addr_err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory filled from a big-endian byte stream, then served to the CPU
// as registered word fetches with bounds and alignment checking.
module instr_mem_loader #(
    parameter int unsigned DEPTH = 256
) (
    input logic                clock,
    input logic                reset,
    instr_mem_loader_if.slave  bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [16:0] DepthCnt = 17'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e      state_q, state_d;
    logic [16:0] wc_q, wc_d;
    logic [1:0]  bc_q, bc_d;
    logic [31:0] asm_q, asm_d;
    logic        fault_q, fault_d;
    logic [31:0] out_q, out_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] mem [DEPTH];

    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] asm_new;
    logic        room;
    logic        accept;
    logic        partial;
    logic [29:0] idx;
    logic        hit;

    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        bc_d      = bc_q;
        asm_d     = asm_q;
        fault_d   = fault_q;
        mem_we    = 1'b0;
        mem_wdata = asm_q;
        room      = (wc_q < DepthCnt);
        accept    = 1'b0;
        partial   = 1'b0;

        // First byte of a word clears the rest so a short final word is zero-padded.
        asm_new = (bc_q == 2'd0) ? 32'h0 : asm_q;
        case (bc_q)
            2'd0:    asm_new[31:24] = bus.load_byte;
            2'd1:    asm_new[23:16] = bus.load_byte;
            2'd2:    asm_new[15:8]  = bus.load_byte;
            default: asm_new[7:0]   = bus.load_byte;
        endcase

        case (state_q)
            StIdle, StRun: begin
                if (bus.load_start) begin
                    state_d = StLoad;
                    wc_d    = '0;
                    bc_d    = '0;
                    fault_d = 1'b0;
                end
            end
            StLoad: begin
                if (bus.load_start) begin
                    wc_d    = '0;
                    bc_d    = '0;
                    fault_d = 1'b0;
                end else begin
                    accept = bus.load_valid && room;
                    if (bus.load_valid && !room) begin
                        fault_d = 1'b1;
                    end
                    if (accept) begin
                        asm_d     = asm_new;
                        mem_wdata = asm_new;
                        if (bc_q == 2'd3) begin
                            mem_we = 1'b1;
                            wc_d   = wc_q + 17'd1;
                            bc_d   = '0;
                        end else begin
                            bc_d = bc_q + 2'd1;
                        end
                    end
                    if (bus.load_end) begin
                        state_d = StRun;
                        bc_d    = '0;
                        // Bytes left over after any same-cycle byte is folded in.
                        partial = accept ? (bc_q != 2'd3) : (bc_q != 2'd0);
                        if (partial) begin
                            mem_we  = 1'b1;
                            wc_d    = wc_q + 17'd1;
                            fault_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        idx        = bus.sel[31:2];
        hit        = (bus.sel[1:0] == 2'b00) && (idx < {13'd0, wc_q});
        out_d      = 32'h0;
        addr_err_d = 1'b0;
        if (state_q == StRun) begin
            out_d      = hit ? mem[idx[AW-1:0]] : 32'h0;
            addr_err_d = !hit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            wc_q       <= '0;
            bc_q       <= '0;
            asm_q      <= '0;
            fault_q    <= 1'b0;
            out_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            bc_q       <= bc_d;
            asm_q      <= asm_d;
            fault_q    <= fault_d;
            out_q      <= out_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array is never cleared; word_count alone decides what is readable.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem[wc_q[AW-1:0]] <= mem_wdata;
        end
    end

    assign bus.load_ready = (state_q == StLoad) && room;
    assign bus.loading    = (state_q == StLoad);
    assign bus.word_count = wc_q;
    assign bus.fault      = fault_q;
    assign bus.out        = out_q;
    assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: two loaders (DEPTH 256 and 4) share stimulus; a byte-queue style
// reference model predicts every cycle's outputs and a monitor compares them.
module tb_instr_mem_loader;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instr_mem_loader_if bus_a ();
    instr_mem_loader_if bus_b ();

    instr_mem_loader #(.DEPTH(256)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    instr_mem_loader #(.DEPTH(4))   dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    typedef struct packed {
        logic [31:0] out;
        logic        addr_err;
        logic        load_ready;
        logic        loading;
        logic        fault;
        logic [16:0] word_count;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 loading, 2 running.
    int unsigned depth_m [2] = '{256, 4};
    int          mode_m  [2];
    int unsigned wc_m    [2];
    bit          fault_m [2];
    int          pend_n  [2];
    logic [31:0] pend_w  [2];
    logic [31:0] mem_m   [2][256];

    function automatic exp_t model_step(int d, bit rst, bit ls, bit lv, logic [7:0] lb,
                                        bit le, logic [31:0] s);
        exp_t e;
        int unsigned idx;
        idx        = s >> 2;
        e.out      = 32'h0;
        e.addr_err = 1'b0;
        if (!rst && mode_m[d] == 2) begin
            if (s % 4 == 0 && idx < wc_m[d]) e.out = mem_m[d][idx];
            else e.addr_err = 1'b1;
        end
        if (rst) begin
            mode_m[d] = 0; wc_m[d] = 0; fault_m[d] = 0; pend_n[d] = 0; pend_w[d] = 0;
        end else if (ls) begin
            mode_m[d] = 1; wc_m[d] = 0; fault_m[d] = 0; pend_n[d] = 0; pend_w[d] = 0;
        end else if (mode_m[d] == 1) begin
            if (lv) begin
                if (wc_m[d] < depth_m[d]) begin
                    pend_w[d] = pend_w[d] | ({24'h0, lb} << (24 - 8 * pend_n[d]));
                    pend_n[d]++;
                    if (pend_n[d] == 4) begin
                        mem_m[d][wc_m[d]] = pend_w[d];
                        wc_m[d]++;
                        pend_n[d] = 0;
                        pend_w[d] = 0;
                    end
                end else begin
                    fault_m[d] = 1;
                end
            end
            if (le) begin
                if (pend_n[d] > 0) begin
                    mem_m[d][wc_m[d]] = pend_w[d];
                    wc_m[d]++;
                    fault_m[d] = 1;
                end
                pend_n[d] = 0;
                pend_w[d] = 0;
                mode_m[d] = 2;
            end
        end
        e.loading    = (mode_m[d] == 1);
        e.load_ready = (mode_m[d] == 1) && (wc_m[d] < depth_m[d]);
        e.fault      = fault_m[d];
        e.word_count = wc_m[d][16:0];
        return e;
    endfunction

    task automatic cyc(input bit rst, input bit ls, input bit lv, input logic [7:0] lb,
                       input bit le, input logic [31:0] s);
        @(negedge clock);
        reset            = rst;
        bus_a.load_start = ls; bus_a.load_valid = lv; bus_a.load_byte = lb;
        bus_a.load_end   = le; bus_a.sel        = s;
        bus_b.load_start = ls; bus_b.load_valid = lv; bus_b.load_byte = lb;
        bus_b.load_end   = le; bus_b.sel        = s;
        exp_a.push_back(model_step(0, rst, ls, lv, lb, le, s));
        exp_b.push_back(model_step(1, rst, ls, lv, lb, le, s));
    endtask

    task automatic send_byte(input logic [7:0] b);
        cyc(1'b0, 1'b0, 1'b1, b, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] s);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, s);
    endtask

    task automatic start_load();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);
    endtask

    task automatic end_load();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input exp_t a);
        chk({tag, ".out"},        a.out,                 e.out);
        chk({tag, ".addr_err"},   {31'h0, a.addr_err},   {31'h0, e.addr_err});
        chk({tag, ".load_ready"}, {31'h0, a.load_ready}, {31'h0, e.load_ready});
        chk({tag, ".loading"},    {31'h0, a.loading},    {31'h0, e.loading});
        chk({tag, ".fault"},      {31'h0, a.fault},      {31'h0, e.fault});
        chk({tag, ".word_count"}, {15'h0, a.word_count}, {15'h0, e.word_count});
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                a = '{bus_a.out, bus_a.addr_err, bus_a.load_ready, bus_a.loading,
                      bus_a.fault, bus_a.word_count};
                compare("a", e, a);
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                a = '{bus_b.out, bus_b.addr_err, bus_b.load_ready, bus_b.loading,
                      bus_b.fault, bus_b.word_count};
                compare("b", e, a);
            end
        end
    end

    logic [7:0] prog1 [8] = '{8'h3C, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h00};
    logic [7:0] prog2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    initial begin
        reset = 1'b1;
        bus_a.load_start = 0; bus_a.load_valid = 0; bus_a.load_byte = 0;
        bus_a.load_end   = 0; bus_a.sel = 0;
        bus_b.load_start = 0; bus_b.load_valid = 0; bus_b.load_byte = 0;
        bus_b.load_end   = 0; bus_b.sel = 0;

        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 32'h0);
        fetch(32'h0);
        fetch(32'h4);

        // Two-word program, then good and bad fetches.
        start_load();
        foreach (prog1[i]) send_byte(prog1[i]);
        end_load();
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'h2); fetch(32'h0);

        // Five bytes leave a padded partial word.
        start_load();
        foreach (prog2[i]) send_byte(prog2[i]);
        end_load();
        fetch(32'h4); fetch(32'h0); fetch(32'h8);

        // Seventeen bytes overflow the 4-word instance.
        start_load();
        for (int i = 1; i <= 17; i++) send_byte(8'(i));
        end_load();
        fetch(32'hC); fetch(32'h0); fetch(32'h10);

        // Reset mid-load, then a clean 4-byte load.
        start_load();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h60 + i));
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        fetch(32'h0);
        start_load();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i));
        end_load();
        fetch(32'h0); fetch(32'h4);

        // load_start beats a coincident byte; a byte coincident with load_end is kept.
        start_load();
        send_byte(8'h10);
        cyc(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 32'h0);
        send_byte(8'h12); send_byte(8'h13);
        cyc(1'b0, 1'b0, 1'b1, 8'h14, 1'b1, 32'h0);
        fetch(32'h0);
        start_load();
        for (int i = 0; i < 3; i++) send_byte(8'(8'h20 + i));
        cyc(1'b0, 1'b0, 1'b1, 8'h23, 1'b1, 32'h0);
        fetch(32'h0); fetch(32'h4);
        cyc(1'b0, 1'b1, 1'b1, 8'h30, 1'b1, 32'h0);
        end_load();
        fetch(32'h0);

        // Fill the 256-word instance past capacity.
        start_load();
        for (int i = 0; i < 1030; i++) send_byte(8'($urandom));
        end_load();
        fetch(32'd1020); fetch(32'd1024); fetch(32'd0); fetch(32'd512);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          rst, ls, lv, le;
            logic [31:0] s;
            int          k;
            rst = ($urandom_range(0, 199) == 0);
            ls  = ($urandom_range(0, 99) < 3);
            lv  = ($urandom_range(0, 99) < 60);
            le  = ($urandom_range(0, 99) < 3);
            k   = $urandom_range(0, 9);
            if (k < 6)      s = 32'($urandom_range(0, 40)) << 2;
            else if (k < 8) s = 32'($urandom_range(0, 160));
            else            s = $urandom;
            cyc(rst, ls, lv, 8'($urandom), le, s);
        end

        for (int i = 0; i < 10 && (exp_a.size() > 0 || exp_b.size() > 0); i++) begin
            @(posedge clock);
            #2;
        end
        n_checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0/0",
                     exp_a.size(), exp_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction-memory depth in 32-bit words; power of two, 4..65536.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load_start  input  1  one-cycle pulse that begins or restarts a program load.
REQ-005 SHALL have port load_valid  input  1  load_byte is valid this cycle.
REQ-006 SHALL have port load_byte  input  8  program byte stream, big-endian within each word.
REQ-007 SHALL have port load_end  input  1  one-cycle pulse that ends the load.
REQ-008 SHALL have port load_ready  output  1  a byte is accepted when load_valid and load_ready are both 1.
REQ-009 SHALL have port loading  output  1  high while in state LOAD.
REQ-010 SHALL have port word_count  output  17  number of words written by the last or current load.
REQ-011 SHALL have port fault  output  1  sticky flag for a partial final word or an overflow.
REQ-012 SHALL have port sel  input  32  CPU fetch byte address.
REQ-013 SHALL have port out  output  32  instruction word returned to the CPU.
REQ-014 SHALL have port addr_err  output  1  one-cycle pulse for a bad fetch address.

Function
REQ-015 SHALL implement the states IDLE, LOAD and RUN; reset enters IDLE.
REQ-016 SHALL make these transitions: IDLE or RUN, on load_start, goes to LOAD; LOAD, on load_start, restarts LOAD; LOAD, on load_end, goes to RUN. No other transitions exist.
REQ-017 SHALL, on entry to LOAD, clear word_count, the byte counter and fault.
REQ-018 SHALL drive load_ready = 1 in LOAD while word_count < DEPTH, and 0 otherwise.
REQ-019 SHALL, in LOAD, place accepted bytes into a word assembly register, with bytes 0..3 mapped to bits [31:24], [23:16], [15:8] and [7:0] in that order.
REQ-020 SHALL, on the fourth accepted byte, write the assembled word to memory[word_count] on the same edge, increment word_count, and reset the byte counter to 0.
REQ-021 SHALL, when load_end arrives with a non-zero byte counter, zero-pad the low bytes, write the word, increment word_count and set fault.
REQ-022 SHALL, when load_valid=1 while word_count = DEPTH in LOAD, drop the byte and set fault.
REQ-023 SHALL give load_start priority when it coincides with load_valid or load_end: the byte is dropped, load_end is ignored, and LOAD restarts.
REQ-024 SHALL, when load_valid and load_end coincide without load_start, accept the byte first and then apply REQ-021 and the transition to RUN.
REQ-025 SHALL register fetch reads with 1-cycle latency: out in cycle N+1 reflects sel in cycle N.
REQ-026 SHALL, in RUN with sel[1:0] = 0 and index = sel >> 2 < word_count, return out = memory[index].
REQ-027 SHALL, in RUN when sel[1:0] != 0 or index >= word_count, return out = 32'h0000_0000 (NOP) and pulse addr_err in the same cycle as that out.
REQ-028 SHALL drive out = 0 and addr_err = 0 in IDLE and in LOAD; the CPU fetches NOPs in these states.
REQ-029 SHALL treat memory contents above word_count as unreadable: they always read as 0.
REQ-030 SHALL keep fault set until the next entry to LOAD or a reset.

Reset
REQ-031 SHALL, with reset = 1 at a rising edge, set: state IDLE, out = 0, addr_err = 0, load_ready = 0, loading = 0, word_count = 0, fault = 0, byte counter = 0.
REQ-032 SHALL let reset in mid-load abandon the load; memory array contents are not cleared but are unreadable per REQ-029.
REQ-033 SHALL give reset priority over every other input.

Verification
REQ-034 SHALL pass: reset, load_start, bytes 3C,08,00,05,21,09,00,00, load_end -> word_count = 2, fault = 0; sel = 0 gives out = 3C080005 one cycle later; sel = 4 gives out = 21090000.
REQ-035 SHALL pass: after REQ-034, sel = 8 -> out = 0 with addr_err = 1; sel = 2 -> out = 0 with addr_err = 1.
REQ-036 SHALL pass: load of 5 bytes AA,BB,CC,DD,EE then load_end -> word_count = 2, memory[1] reads EE000000, fault = 1.
REQ-037 SHALL pass: DEPTH = 4, load of 17 bytes -> load_ready = 0 after the 16th byte, word_count = 4, fault = 1, memory[3] holds bytes 13..16.
REQ-038 SHALL pass: reset asserted after 6 bytes of a load -> next cycle state IDLE, word_count = 0, out = 0; a following load_start and a 4-byte load work normally.
REQ-039 SHALL pass: load_start coinciding with load_valid (byte 11) -> byte dropped and word_count = 0; load_valid coinciding with load_end -> byte included in the final word.
